instr_fetch: RTL and testbench

Instruction fetch unit for the single-cycle/lab datapath. It drives the byte address into the 256-byte instruction memory and captures the returned 32-bit word each cycle. Fetched words go into a 2-entry buffer with a valid/ready handshake toward decode, with branch/jump redirect and flush. It sits between the PC logic and the decoder and is the initiator/reader side of the instruction-memory interface.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_fifo.sv | 78 +++++++
 rtl/instr_fetch.sv | 96 +++++++++
 tb/tb_instr_fetch.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: constants and types shared by the fetch unit.
// A buffer entry is the word plus the address it came from.
package fetch_pkg;

   localparam int ADDR_W = 8;
   localparam int PC_STEP = 4;
   localparam logic [ADDR_W-1:0] RESET_PC = 8'h00;
   localparam logic [31:0] NOP_INSTR = 32'h00007033;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [31:0]       instr;
   } fetch_entry_t;

   typedef enum logic [1:0] {
      FETCH,
      HOLD,
      FLUSH
   } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: two-entry registered buffer, shift style.
// Head is entry 0, so outputs hold their value once emptied.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  fetch_entry_t din,
   output logic [1:0]   count,
   output logic         valid,
   output fetch_entry_t head
);

   localparam logic [1:0] FULL = 2'(DEPTH);

   fetch_entry_t e0, e1;
   fetch_entry_t e0_n, e1_n;
   logic [1:0]   cnt, cnt_n;
   logic         do_push, do_pop;

   // next entries and occupancy from push/pop/flush
   always_comb begin
      e0_n    = e0;
      e1_n    = e1;
      cnt_n   = cnt;
      do_pop  = pop && (cnt != 2'd0);
      do_push = push && ((cnt != FULL) || do_pop);
      if (flush) begin
         cnt_n = 2'd0;
      end else begin
         unique case ({do_push, do_pop})
            2'b10: begin
               if (cnt == 2'd0) e0_n = din;
               else             e1_n = din;
               cnt_n = cnt + 2'd1;
            end
            2'b01: begin
               if (cnt == FULL) e0_n = e1;
               cnt_n = cnt - 2'd1;
            end
            2'b11: begin
               if (cnt == FULL) begin
                  e0_n = e1;
                  e1_n = din;
               end else begin
                  e0_n = din;
               end
            end
            default: begin
               cnt_n = cnt;
            end
         endcase
      end
   end

   // entry and count registers
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= 2'd0;
         e0  <= '0;
         e1  <= '0;
      end else begin
         cnt <= cnt_n;
         e0  <= e0_n;
         e1  <= e1_n;
      end
   end

   assign count = cnt;
   assign valid = (cnt != 2'd0);
   assign head  = e0;

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: pc register and fetch control in front of decode.
// Redirect beats hold; hold only when full with no pop.
module instr_fetch #(
   parameter int ADDR_W = fetch_pkg::ADDR_W,
   parameter logic [ADDR_W-1:0] RESET_PC = fetch_pkg::RESET_PC,
   parameter int DEPTH = 2
) (
   input  logic              clk,
   input  logic              reset,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_instr,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [ADDR_W-1:0] out_pc
);

   import fetch_pkg::*;

   logic [ADDR_W-1:0] pc, pc_n;
   logic [1:0]        count;
   logic              full, pop, push, flush;
   fetch_state_e      state;
   fetch_entry_t      din, head;
   logic [1:0]        unused_lsb;

   assign unused_lsb = redirect_pc[1:0];
   assign full       = (count == 2'(DEPTH));
   assign pop        = out_valid & out_ready;
   assign din        = '{pc: pc, instr: imem_instr};

   // classify the cycle
   always_comb begin
      state = FETCH;
      unique case (1'b1)
         redirect_valid:
            state = FLUSH;
         !redirect_valid && full && !pop:
            state = HOLD;
         !redirect_valid && !(full && !pop):
            state = FETCH;
         default:
            state = FETCH;
      endcase
   end

   // push, flush and next pc per cycle class
   always_comb begin
      push  = 1'b0;
      flush = 1'b0;
      pc_n  = pc;
      unique case (state)
         FETCH: begin
            push = 1'b1;
            pc_n = pc + ADDR_W'(PC_STEP);
         end
         FLUSH: begin
            flush = 1'b1;
            pc_n  = {redirect_pc[ADDR_W-1:2], 2'b00};
         end
         HOLD: begin
            pc_n = pc;
         end
         default: begin
            pc_n = pc;
         end
      endcase
   end

   // fetch address register
   always_ff @(posedge clk) begin
      if (reset) pc <= RESET_PC;
      else       pc <= pc_n;
   end

   fetch_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .flush (flush),
      .din   (din),
      .count (count),
      .valid (out_valid),
      .head  (head)
   );

   assign imem_addr = pc;
   assign out_instr = head.instr;
   assign out_pc    = head.pc;

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed checks of fetch, backpressure,
// redirect, wrap and reset against hand-computed values.
module tb_instr_fetch;

   logic        clk;
   logic        reset;
   logic [7:0]  imem_addr;
   logic [31:0] imem_instr;
   logic        redirect_valid;
   logic [7:0]  redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [7:0]  out_pc;

   logic [31:0] mem [64];
   logic [7:0]  acc [$];

   integer n_checks;
   integer n_fail;

   instr_fetch dut (
      .clk            (clk),
      .reset          (reset),
      .imem_addr      (imem_addr),
      .imem_instr     (imem_instr),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc)
   );

   assign imem_instr = mem[imem_addr[7:2]];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // record every accepted head word
   always @(posedge clk) begin
      if (!reset && out_valid && out_ready) acc.push_back(out_pc);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset          = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 8'h00;
      out_ready      = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if ({out_valid, out_pc, out_instr} !== 41'h0) begin
         n_fail++;
         $display("FAIL reset_out: got %h want %h",
                  {out_valid, out_pc, out_instr}, 41'h0);
      end
      n_checks++;
      if (imem_addr !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_addr: got %h want 00", imem_addr);
      end
   endtask

   task automatic test_stream();
      logic [40:0] exp;
      do_reset();
      out_ready = 1'b1;
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL stream_c0: got %b want 0", out_valid);
      end
      tick();
      exp = {1'b1, 8'h00, 32'h00007033};
      n_checks++;
      if ({out_valid, out_pc, out_instr} !== exp) begin
         n_fail++;
         $display("FAIL stream_c1: got %h want %h",
                  {out_valid, out_pc, out_instr}, exp);
      end
      tick();
      exp = {1'b1, 8'h04, 32'h00100093};
      n_checks++;
      if ({out_valid, out_pc, out_instr} !== exp) begin
         n_fail++;
         $display("FAIL stream_c2: got %h want %h",
                  {out_valid, out_pc, out_instr}, exp);
      end
      tick();
      exp = {1'b1, 8'h08, 32'h00200113};
      n_checks++;
      if ({out_valid, out_pc, out_instr} !== exp) begin
         n_fail++;
         $display("FAIL stream_c3: got %h want %h",
                  {out_valid, out_pc, out_instr}, exp);
      end
   endtask

   task automatic test_back_to_back();
      logic [40:0] exp;
      for (int k = 3; k < 8; k++) begin
         tick();
         exp = {1'b1, 8'(k * 4), 32'h10000000 | 32'(k)};
         n_checks++;
         if ({out_valid, out_pc, out_instr} !== exp) begin
            n_fail++;
            $display("FAIL b2b_%0d: got %h want %h", k,
                     {out_valid, out_pc, out_instr}, exp);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [40:0] exp;
      logic [7:0]  ea;
      do_reset();
      exp = {1'b1, 8'h00, 32'h00007033};
      for (int k = 1; k <= 5; k++) begin
         tick();
         ea = (k == 1) ? 8'h04 : 8'h08;
         n_checks++;
         if ({out_valid, out_pc, out_instr} !== exp) begin
            n_fail++;
            $display("FAIL bp_head_%0d: got %h want %h", k,
                     {out_valid, out_pc, out_instr}, exp);
         end
         n_checks++;
         if (imem_addr !== ea) begin
            n_fail++;
            $display("FAIL bp_addr_%0d: got %h want %h",
                     k, imem_addr, ea);
         end
      end
      out_ready = 1'b1;
      tick();
      exp = {1'b1, 8'h04, 32'h00100093};
      n_checks++;
      if ({out_valid, out_pc, out_instr} !== exp) begin
         n_fail++;
         $display("FAIL bp_rel1: got %h want %h",
                  {out_valid, out_pc, out_instr}, exp);
      end
      tick();
      exp = {1'b1, 8'h08, 32'h00200113};
      n_checks++;
      if ({out_valid, out_pc, out_instr} !== exp) begin
         n_fail++;
         $display("FAIL bp_rel2: got %h want %h",
                  {out_valid, out_pc, out_instr}, exp);
      end
   endtask

   task automatic test_redirect();
      logic [40:0] exp;
      do_reset();
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) tick();
      exp = {1'b1, 8'h0C, 32'h10000003};
      n_checks++;
      if ({out_valid, out_pc, out_instr} !== exp) begin
         n_fail++;
         $display("FAIL redir_c4: got %h want %h",
                  {out_valid, out_pc, out_instr}, exp);
      end
      redirect_valid = 1'b1;
      redirect_pc    = 8'h23;
      tick();
      redirect_valid = 1'b0;
      exp = {1'b0, 8'h0C, 32'h10000003};
      n_checks++;
      if ({out_valid, out_pc, out_instr} !== exp) begin
         n_fail++;
         $display("FAIL redir_c5: got %h want %h",
                  {out_valid, out_pc, out_instr}, exp);
      end
      n_checks++;
      if (imem_addr !== 8'h20) begin
         n_fail++;
         $display("FAIL redir_addr: got %h want 20", imem_addr);
      end
      tick();
      exp = {1'b1, 8'h20, 32'h00208433};
      n_checks++;
      if ({out_valid, out_pc, out_instr} !== exp) begin
         n_fail++;
         $display("FAIL redir_c6: got %h want %h",
                  {out_valid, out_pc, out_instr}, exp);
      end
   endtask

   task automatic test_wrap();
      logic [40:0] exp;
      do_reset();
      out_ready      = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 8'hFC;
      tick();
      redirect_valid = 1'b0;
      n_checks++;
      if ({out_valid, imem_addr} !== {1'b0, 8'hFC}) begin
         n_fail++;
         $display("FAIL wrap_c1: got %h want 0fc",
                  {out_valid, imem_addr});
      end
      tick();
      exp = {1'b1, 8'hFC, 32'h12345678};
      n_checks++;
      if ({out_valid, out_pc, out_instr} !== exp) begin
         n_fail++;
         $display("FAIL wrap_fc: got %h want %h",
                  {out_valid, out_pc, out_instr}, exp);
      end
      tick();
      exp = {1'b1, 8'h00, 32'h00007033};
      n_checks++;
      if ({out_valid, out_pc, out_instr} !== exp) begin
         n_fail++;
         $display("FAIL wrap_00: got %h want %h",
                  {out_valid, out_pc, out_instr}, exp);
      end
      n_checks++;
      if (imem_addr !== 8'h04) begin
         n_fail++;
         $display("FAIL wrap_addr: got %h want 04", imem_addr);
      end
   endtask

   task automatic test_redirect_pop_full();
      logic [40:0] exp;
      do_reset();
      tick();
      tick();
      acc.delete();
      out_ready      = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 8'h41;
      tick();
      redirect_valid = 1'b0;
      n_checks++;
      if ({out_valid, imem_addr} !== {1'b0, 8'h40}) begin
         n_fail++;
         $display("FAIL rpf_flush: got %h want 040",
                  {out_valid, imem_addr});
      end
      tick();
      exp = {1'b1, 8'h40, 32'h10000010};
      n_checks++;
      if ({out_valid, out_pc, out_instr} !== exp) begin
         n_fail++;
         $display("FAIL rpf_target: got %h want %h",
                  {out_valid, out_pc, out_instr}, exp);
      end
      tick();
      exp = {1'b1, 8'h44, 32'h10000011};
      n_checks++;
      if ({out_valid, out_pc, out_instr} !== exp) begin
         n_fail++;
         $display("FAIL rpf_next: got %h want %h",
                  {out_valid, out_pc, out_instr}, exp);
      end
      n_checks++;
      if (acc.size() != 2 || acc[0] !== 8'h00 ||
          acc[1] !== 8'h40) begin
         n_fail++;
         $display("FAIL rpf_sb: got n=%0d %h %h want n=2 00 40",
                  acc.size(), acc[0], acc[1]);
      end
   endtask

   task automatic test_reset_mid();
      logic [40:0] exp;
      do_reset();
      tick();
      tick();
      reset          = 1'b1;
      out_ready      = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 8'h80;
      tick();
      reset          = 1'b0;
      redirect_valid = 1'b0;
      n_checks++;
      if ({out_valid, imem_addr, out_pc, out_instr} !== 49'h0) begin
         n_fail++;
         $display("FAIL rmid_c1: got %h want 0",
                  {out_valid, imem_addr, out_pc, out_instr});
      end
      tick();
      exp = {1'b1, 8'h00, 32'h00007033};
      n_checks++;
      if ({out_valid, out_pc, out_instr} !== exp) begin
         n_fail++;
         $display("FAIL rmid_c2: got %h want %h",
                  {out_valid, out_pc, out_instr}, exp);
      end
      tick();
      exp = {1'b1, 8'h04, 32'h00100093};
      n_checks++;
      if ({out_valid, out_pc, out_instr} !== exp) begin
         n_fail++;
         $display("FAIL rmid_c3: got %h want %h",
                  {out_valid, out_pc, out_instr}, exp);
      end
   endtask

   initial begin
      n_checks       = 0;
      n_fail         = 0;
      reset          = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 8'h00;
      out_ready      = 1'b0;
      for (int i = 0; i < 64; i++) mem[i] = 32'h10000000 | 32'(i);
      mem[0]  = 32'h00007033;
      mem[1]  = 32'h00100093;
      mem[2]  = 32'h00200113;
      mem[8]  = 32'h00208433;
      mem[63] = 32'h12345678;
      test_reset();
      test_stream();
      test_back_to_back();
      test_backpressure();
      test_redirect();
      test_wrap();
      test_redirect_pop_full();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
